rom_streamer: RTL and testbench
===============================

# rom_streamer

Read-side master for the synchronous `rom` block: on a `start` pulse it walks a contiguous, wrapping address range of the ROM and delivers each word on a valid/ready output stream. It owns the ROM's address port, absorbs the one-cycle registered read latency, and buffers words so a stalling consumer never loses data. It sits between a ROM instance and any downstream consumer, such as a pattern generator or a display driver.

## Interface
- `ADDR_WIDTH`, 8: ROM address width. Must match the attached ROM.
- `DATA_WIDTH`, 32: ROM word width. Must match the attached ROM.
- `clk` in 1: single clock, shared with the ROM.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request a burst. Sampled only in IDLE.
- `base_addr` in ADDR_WIDTH: first address. Sampled with `start`.
- `length` in ADDR_WIDTH+1: number of words, 0 to 2**ADDR_WIDTH. Sampled with `start`.
- `busy` out 1: burst in progress.
- `done` out 1: one-cycle pulse when the last word is accepted.
- `rom_addr` out ADDR_WIDTH: registered address driven to the ROM `addr` port.
- `rom_q` in DATA_WIDTH: ROM `q` output.
- `out_data` out DATA_WIDTH: stream data. Driven from the FIFO head.
- `out_valid` out 1: stream valid.
- `out_ready` in 1: stream ready.

## Operation
- States:
  - IDLE: `start` moves to RUN when `length` ≠ 0, or to DONE when `length` = 0.
  - RUN: issues reads. Moves to DRAIN after the final address is issued.
  - DRAIN: holds until the FIFO is empty and nothing is in flight, then moves to DONE.
  - DONE: lasts one cycle, then returns to IDLE.
- `start` in any state other than IDLE is ignored.
- Read pipeline:
  - A read is issued by loading `rom_addr` and setting valid bit `v0`.
  - On the next edge `v0` shifts to `v1`, while the ROM registers `q`.
  - On the edge after that, `rom_q` is written into the FIFO when `v1` is set.
  - In-flight count = `v0` + `v1`.
- Issue rule: a read issues in RUN only when the remaining word count is nonzero and FIFO occupancy + in-flight < 4.
- Addressing:
  - `rom_addr` increments by 1 per issued read, modulo 2**ADDR_WIDTH; 8'hFF wraps to 8'h00.
  - The remaining count is a down-counter of width ADDR_WIDTH+1.
- Handshake:
  - A word transfers when `out_valid` and `out_ready` are both high.
  - `out_data` and `out_valid` stay stable while `out_valid`=1 and `out_ready`=0.
  - `out_valid` = FIFO not empty.
- `done` fires in the DONE state.
  - With `length` = 0 it fires one cycle after `start`, with no beats.
  - Otherwise it fires in the cycle after the final transfer.
- `busy` is high in RUN, DRAIN and DONE.
- `rom_addr` keeps its last value outside a burst.

## Timing
- Reset (asynchronous assert, synchronous release): state=IDLE, FIFO empty, `v0`=`v1`=0, `busy`=0, `done`=0, `out_valid`=0, `out_data`=0, `rom_addr`=0.
- Reset mid-burst aborts immediately. No `done` is produced and buffered words are discarded.
- Latency, with `start` high in cycle 0:
  - cycle 1: `rom_addr`=`base_addr` and `busy`=1.
  - cycle 2: the ROM outputs the word.
  - cycle 3: `out_valid`=1 with word 0.
- Throughput: one word per cycle while `out_ready` is held high.
- Backpressure: with `out_ready` low, at most 4 words are buffered and issuing stops. Issuing resumes the cycle after a pop frees a slot.
- Simultaneous FIFO push and pop in the same cycle leaves occupancy unchanged. Push while full cannot occur because of the issue rule.

## Structure
- Shared package/header `rom_stream_pkg`:
  - FSM state encoding (IDLE, RUN, DRAIN, DONE).
  - `FIFO_DEPTH`=4 and the 2-bit pointer width.
- Sub-module `stream_fifo`: DEPTH=4, DATA_WIDTH parameter; push/pop/full/empty/count ports.
- `rom_streamer` contains the FSM, address and remaining counters, and the `v0`/`v1` pipeline.
- Testbench instantiates the existing `rom`, loaded so that mem[a] = 32'hA500_0000 + a.

## Test plan
- Basic burst: `base_addr`=8'h10, `length`=5, `out_ready`=1.
  - Beats 32'hA500_0010..14 on consecutive cycles.
  - First `out_valid` in cycle 3.
  - `done` fires the cycle after the 5th beat.
- Wrap-around: `base_addr`=8'hFE, `length`=4 → data for addresses FE, FF, 00, 01 in order.
- Backpressure: `length`=8, `out_ready` low for cycles 3–12.
  - `rom_addr` stops advancing after 4 words are buffered.
  - `out_data` stays 32'hA500_0000 throughout.
  - After release, all 8 words arrive in order with no loss or duplication.
- Random `out_ready` (50%) with `length`=256 from `base_addr`=0.
  - All 256 words arrive in order.
  - Exactly one `done`.
- Zero length and ignored start:
  - `length`=0 → `done` in cycle 1 with no `out_valid`.
  - `start` pulsed during RUN → ignored, burst count unchanged.
- Mid-burst reset: `rst_n` low in cycle 5 of a `length`=10 burst.
  - All outputs go to their reset values immediately.
  - A new burst started after release behaves correctly.

Source files
------------

// File: rtl/rom_stream_pkg.sv
// Shared definitions for the ROM read streamer: FSM encoding and FIFO geometry.
package rom_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int FIFO_DEPTH = 4;
  localparam int PTR_WIDTH  = 2;
  localparam int CNT_WIDTH  = 3;

  function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] ptr);
    return ptr + 2'd1;
  endfunction

endpackage

// File: rtl/stream_fifo.sv
// Four-entry synchronous FIFO with show-ahead head; absorbs ROM words while the consumer stalls.
module stream_fifo
  import rom_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  full,
  output logic                  empty,
  output logic [CNT_WIDTH-1:0]  count
);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_WIDTH-1:0]  wr_ptr_r;
  logic [PTR_WIDTH-1:0]  rd_ptr_r;
  logic [CNT_WIDTH-1:0]  count_r;
  logic                  push_ok_s;
  logic                  pop_ok_s;

  // Qualify requests against occupancy so the pointers can never overrun.
  always_comb begin
    push_ok_s = 1'b0;
    pop_ok_s  = 1'b0;
    if (push && (count_r != CNT_WIDTH'(DEPTH))) begin
      push_ok_s = 1'b1;
    end else begin
      push_ok_s = 1'b0;
    end
    if (pop && (count_r != 3'd0)) begin
      pop_ok_s = 1'b1;
    end else begin
      pop_ok_s = 1'b0;
    end
  end

  // Storage, pointers and occupancy counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= 2'd0;
      rd_ptr_r <= 2'd0;
      count_r  <= 3'd0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= ptr_inc(wr_ptr_r);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + 3'd1;
        2'b01:   count_r <= count_r - 3'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign pop_data = mem_r[rd_ptr_r];
  assign full     = (count_r == CNT_WIDTH'(DEPTH));
  assign empty    = (count_r == 3'd0);
  assign count    = count_r;

endmodule

// File: rtl/rom_streamer.sv
// Burst reader for a registered-output ROM: walks a wrapping address range and
// streams each word out over valid/ready, buffering enough to ride out stalls.
module rom_streamer
  import rom_stream_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_q,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  state_t                state_r;
  logic [ADDR_WIDTH-1:0] rom_addr_r;
  logic [ADDR_WIDTH:0]   rem_r;
  logic                  v0_r;
  logic                  v1_r;
  logic                  busy_r;
  logic                  done_r;

  logic [DATA_WIDTH-1:0] fifo_data_s;
  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  logic [CNT_WIDTH-1:0]  fifo_count_s;
  logic                  pop_s;
  logic [CNT_WIDTH-1:0]  inflight_s;
  logic                  can_issue_s;
  logic                  drain_done_s;

  stream_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (v1_r),
    .push_data(rom_q),
    .pop      (pop_s),
    .pop_data (fifo_data_s),
    .full     (fifo_full_s),
    .empty    (fifo_empty_s),
    .count    (fifo_count_s)
  );

  // Reads are only issued when a FIFO slot is already reserved for them,
  // so a push can never meet a full FIFO.
  always_comb begin
    pop_s        = (!fifo_empty_s) && out_ready;
    inflight_s   = {2'b00, v0_r} + {2'b00, v1_r};
    can_issue_s  = 1'b0;
    drain_done_s = 1'b0;
    if ((rem_r != '0) && !fifo_full_s && ((fifo_count_s + inflight_s) < 3'd4)) begin
      can_issue_s = 1'b1;
    end else begin
      can_issue_s = 1'b0;
    end
    // Leaving DRAIN on the last pop lets done land in the very next cycle.
    if (!v0_r && !v1_r && (fifo_empty_s || ((fifo_count_s == 3'd1) && pop_s))) begin
      drain_done_s = 1'b1;
    end else begin
      drain_done_s = 1'b0;
    end
  end

  // Burst FSM, address/remaining counters and the two-stage read-valid pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      rom_addr_r <= '0;
      rem_r      <= '0;
      v0_r       <= 1'b0;
      v1_r       <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      v1_r   <= v0_r;
      v0_r   <= 1'b0;
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            busy_r <= 1'b1;
            if (length == '0) begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
            end else begin
              state_r    <= ST_RUN;
              rom_addr_r <= base_addr;
              v0_r       <= 1'b1;
              rem_r      <= length - {{ADDR_WIDTH{1'b0}}, 1'b1};
            end
          end
        end
        ST_RUN: begin
          if (rem_r == '0) begin
            state_r <= ST_DRAIN;
          end else if (can_issue_s) begin
            rom_addr_r <= rom_addr_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            v0_r       <= 1'b1;
            rem_r      <= rem_r - {{ADDR_WIDTH{1'b0}}, 1'b1};
          end
        end
        ST_DRAIN: begin
          if (drain_done_s) begin
            state_r <= ST_DONE;
            done_r  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign rom_addr  = rom_addr_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign out_data  = fifo_data_s;
  assign out_valid = !fifo_empty_s;

endmodule

// File: tb/tb_rom_streamer.sv
// Self-checking bench for rom_streamer with a registered ROM model holding A500_0000 + addr.
module tb_rom_streamer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  base_addr;
  logic [8:0]  length;
  logic        busy;
  logic        done;
  logic [7:0]  rom_addr;
  logic [31:0] rom_q;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;

  logic [31:0] mem [0:255];
  logic [31:0] exp_q [$];
  logic [31:0] exp_w;
  int          checks = 0;
  int          errors = 0;
  int          beats  = 0;
  int          done_cnt = 0;
  int          cyc;

  always #5 clk = ~clk;

  rom_streamer #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .base_addr(base_addr),
    .length   (length),
    .busy     (busy),
    .done     (done),
    .rom_addr (rom_addr),
    .rom_q    (rom_q),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 32'hA500_0000 + a;
  end

  always @(posedge clk) rom_q <= mem[rom_addr];

  // Scoreboard: every accepted beat must match the oldest expected word.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) done_cnt++;
      if (out_valid && out_ready) begin
        beats++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected: got %h, required no beat", out_data);
        end else begin
          exp_w = exp_q.pop_front();
          if (out_data !== exp_w) begin
            errors++;
            $display("FAIL beat_data: got %h, required %h", out_data, exp_w);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives start for one cycle and queues the words the burst must deliver; returns in cycle 1.
  task automatic start_burst(input logic [7:0] b, input logic [8:0] l);
    logic [7:0] a;
    base_addr = b;
    length    = l;
    start     = 1'b1;
    for (int i = 0; i < int'(l); i++) begin
      a = b + i[7:0];
      exp_q.push_back(32'hA500_0000 + {24'h0, a});
    end
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cycles);
    cycles = -1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (done) begin
        cycles = c;
        return;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; base_addr = 8'h00; length = 9'd0; out_ready = 1'b0;
    step(); step();
    @(negedge clk);
    checks += 5;
    if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
    if (done !== 1'b0)       begin errors++; $display("FAIL reset_done: got %b, required 0", done); end
    if (out_valid !== 1'b0)  begin errors++; $display("FAIL reset_valid: got %b, required 0", out_valid); end
    if (out_data !== 32'h0)  begin errors++; $display("FAIL reset_data: got %h, required 0", out_data); end
    if (rom_addr !== 8'h00)  begin errors++; $display("FAIL reset_addr: got %h, required 00", rom_addr); end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    out_ready = 1'b1; beats = 0; done_cnt = 0;
    start_burst(8'h10, 9'd5);
    @(negedge clk);
    checks += 2;
    if (rom_addr !== 8'h10) begin errors++; $display("FAIL basic_c1_addr: got %h, required 10", rom_addr); end
    if (busy !== 1'b1)      begin errors++; $display("FAIL basic_c1_busy: got %b, required 1", busy); end
    step(); @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_c2_valid: got %b, required 0", out_valid); end
    for (int c = 3; c <= 7; c++) begin
      step(); @(negedge clk);
      checks += 2;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid_c%0d: got %b, required 1", c, out_valid); end
      if (done !== 1'b0)      begin errors++; $display("FAIL basic_early_done_c%0d: got %b, required 0", c, done); end
    end
    step(); @(negedge clk);
    checks += 3;
    if (done !== 1'b1)       begin errors++; $display("FAIL basic_done_c8: got %b, required 1", done); end
    if (beats != 5)          begin errors++; $display("FAIL basic_beats: got %0d, required 5", beats); end
    if (exp_q.size() != 0)   begin errors++; $display("FAIL basic_leftover: got %0d, required 0", exp_q.size()); end
    step();
  endtask

  task automatic test_wrap();
    out_ready = 1'b1; beats = 0; done_cnt = 0;
    start_burst(8'hFE, 9'd4);
    wait_done(40, cyc);
    step(); @(negedge clk);
    checks += 3;
    if (cyc < 0)           begin errors++; $display("FAIL wrap_done_timeout: got none, required done"); end
    if (beats != 4)        begin errors++; $display("FAIL wrap_beats: got %0d, required 4", beats); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_leftover: got %0d, required 0", exp_q.size()); end
    step();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; beats = 0; done_cnt = 0;
    start_burst(8'h00, 9'd8);
    for (int c = 2; c <= 12; c++) begin
      step(); @(negedge clk);
      if (c >= 3) begin
        checks += 2;
        if (out_valid !== 1'b1)        begin errors++; $display("FAIL bp_valid_c%0d: got %b, required 1", c, out_valid); end
        if (out_data !== 32'hA500_0000) begin errors++; $display("FAIL bp_data_c%0d: got %h, required a5000000", c, out_data); end
      end
      if (c >= 5) begin
        checks++;
        if (rom_addr !== 8'h03) begin errors++; $display("FAIL bp_addr_c%0d: got %h, required 03", c, rom_addr); end
      end
    end
    step();
    out_ready = 1'b1;
    wait_done(40, cyc);
    step(); @(negedge clk);
    checks += 4;
    if (cyc < 0)           begin errors++; $display("FAIL bp_done_timeout: got none, required done"); end
    if (beats != 8)        begin errors++; $display("FAIL bp_beats: got %0d, required 8", beats); end
    if (done_cnt != 1)     begin errors++; $display("FAIL bp_done_count: got %0d, required 1", done_cnt); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL bp_leftover: got %0d, required 0", exp_q.size()); end
    step();
  endtask

  task automatic test_random_ready();
    out_ready = 1'b0; beats = 0; done_cnt = 0; cyc = -1;
    start_burst(8'h00, 9'd256);
    for (int c = 1; c <= 3000; c++) begin
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (done) begin
        cyc = c;
        break;
      end
      step();
    end
    out_ready = 1'b1;
    step(); step(); step(); @(negedge clk);
    checks += 4;
    if (cyc < 0)           begin errors++; $display("FAIL rand_done_timeout: got none, required done"); end
    if (beats != 256)      begin errors++; $display("FAIL rand_beats: got %0d, required 256", beats); end
    if (done_cnt != 1)     begin errors++; $display("FAIL rand_done_count: got %0d, required 1", done_cnt); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL rand_leftover: got %0d, required 0", exp_q.size()); end
    step();
  endtask

  task automatic test_zero_and_ignored_start();
    out_ready = 1'b1; beats = 0; done_cnt = 0;
    start_burst(8'h55, 9'd0);
    @(negedge clk);
    checks += 3;
    if (done !== 1'b1)      begin errors++; $display("FAIL zero_done_c1: got %b, required 1", done); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL zero_valid_c1: got %b, required 0", out_valid); end
    if (busy !== 1'b1)      begin errors++; $display("FAIL zero_busy_c1: got %b, required 1", busy); end
    step(); @(negedge clk);
    checks += 3;
    if (done !== 1'b0)      begin errors++; $display("FAIL zero_done_c2: got %b, required 0", done); end
    if (busy !== 1'b0)      begin errors++; $display("FAIL zero_busy_c2: got %b, required 0", busy); end
    if (beats != 0)         begin errors++; $display("FAIL zero_beats: got %0d, required 0", beats); end
    step();
    beats = 0; done_cnt = 0;
    start_burst(8'h40, 9'd6);
    step();
    base_addr = 8'h80; length = 9'd3; start = 1'b1;
    step();
    start = 1'b0;
    wait_done(40, cyc);
    step(); step(); @(negedge clk);
    checks += 4;
    if (cyc < 0)           begin errors++; $display("FAIL ign_done_timeout: got none, required done"); end
    if (beats != 6)        begin errors++; $display("FAIL ign_beats: got %0d, required 6", beats); end
    if (done_cnt != 1)     begin errors++; $display("FAIL ign_done_count: got %0d, required 1", done_cnt); end
    if (busy !== 1'b0)     begin errors++; $display("FAIL ign_busy_after: got %b, required 0", busy); end
    step();
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b1; beats = 0; done_cnt = 0;
    start_burst(8'h20, 9'd10);
    step(); step(); step(); step();
    rst_n = 1'b0;
    #1;
    checks += 5;
    if (busy !== 1'b0)      begin errors++; $display("FAIL mrst_busy: got %b, required 0", busy); end
    if (done !== 1'b0)      begin errors++; $display("FAIL mrst_done: got %b, required 0", done); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mrst_valid: got %b, required 0", out_valid); end
    if (out_data !== 32'h0) begin errors++; $display("FAIL mrst_data: got %h, required 0", out_data); end
    if (rom_addr !== 8'h00) begin errors++; $display("FAIL mrst_addr: got %h, required 00", rom_addr); end
    exp_q.delete();
    step(); step();
    rst_n = 1'b1;
    step();
    beats = 0; done_cnt = 0;
    start_burst(8'h30, 9'd3);
    wait_done(30, cyc);
    step(); @(negedge clk);
    checks += 4;
    if (cyc < 0)           begin errors++; $display("FAIL mrst_done_timeout: got none, required done"); end
    if (beats != 3)        begin errors++; $display("FAIL mrst_beats: got %0d, required 3", beats); end
    if (done_cnt != 1)     begin errors++; $display("FAIL mrst_done_count: got %0d, required 1", done_cnt); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL mrst_leftover: got %0d, required 0", exp_q.size()); end
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_random_ready();
    test_zero_and_ignored_start();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
